// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared FSM state type and tolerance helper for clk_ratio_meter
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  // An expected period of 0 never matches; difference is taken one bit wider than the operands.
  function automatic logic in_tol(input logic [31:0] per_v, input logic [31:0] exp_v,
                                  input logic [31:0] tol_v);
    logic [32:0] diff;
    if (exp_v == 32'd0) begin
      return 1'b0;
    end
    if (per_v >= exp_v) begin
      diff = {1'b0, per_v} - {1'b0, exp_v};
    end else begin
      diff = {1'b0, exp_v} - {1'b0, per_v};
    end
    return (diff <= {1'b0, tol_v});
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-stage single-bit synchronizer, async active-low reset to 0
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_ratio_meter.sv
// rtl/clk_ratio_meter.sv - measures period/high time of a slow async signal and reports lock
module clk_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_t     state, state_nxt;
  logic             s, s_prev, rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             match;
  logic             arm_hit, meas_hit, tmo_hit, count_en;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (!rise && per_cnt == CNT_MAX) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    arm_hit  = 1'b0;
    meas_hit = 1'b0;
    tmo_hit  = 1'b0;
    count_en = 1'b0;
    if (en && state != IDLE) begin
      if (rise) begin
        arm_hit  = (state == ARM);
        meas_hit = (state == MEASURE);
      end else if (per_cnt == CNT_MAX) begin
        tmo_hit = 1'b1;
      end else begin
        count_en = 1'b1;
      end
    end
  end

  assign match = in_tol(32'(per_cnt), 32'(exp_period), 32'(TOL));

  always_comb begin
    match_nxt = '0;
    if (match) begin
      match_nxt = (match_cnt == LOCK_V) ? match_cnt : match_cnt + 1'b1;
    end
  end

  // Disabling discards any measurement in flight; period/high_time keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else if (!en) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= meas_hit;
      if (arm_hit || meas_hit) begin
        per_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        hi_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
        timeout <= 1'b0;
      end
      if (meas_hit) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
        match_cnt <= match_nxt;
        locked    <= (match_nxt == LOCK_V);
      end
      if (tmo_hit) begin
        per_cnt   <= '0;
        hi_cnt    <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        timeout   <= 1'b1;
      end
      if (count_en) begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
        if (state == MEASURE && s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb/tb_clk_ratio_meter.sv - directed self-checking bench for clk_ratio_meter
module tb_clk_ratio_meter;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic             en;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  // measurement history captured at each meas_valid
  int   vcnt = 0;
  int   dbl  = 0;
  logic prev_mv = 1'b0;
  int   per_h [0:63];
  int   hi_h  [0:63];
  logic lk_h  [0:63];

  clk_ratio_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_CNT(4), .TOL(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .en         (en),
    .exp_period (exp_period),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_mv <= meas_valid;
    if (prev_mv && meas_valid) dbl <= dbl + 1;
    if (meas_valid) begin
      per_h[vcnt[5:0]] <= int'(period);
      hi_h[vcnt[5:0]]  <= int'(high_time);
      lk_h[vcnt[5:0]]  <= locked;
      vcnt <= vcnt + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge clk);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
    #1;
  endtask

  task automatic lock_seq(input string tag);
    int base;
    base = vcnt;
    pulses(1, 3, 2);
    chk({tag, " first edge arms"}, vcnt - base, 0);
    pulses(6, 3, 2);
    chk({tag, " meas count"}, vcnt - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s period[%0d]", tag, i), per_h[base+i], 5);
      chk($sformatf("%s high[%0d]", tag, i), hi_h[base+i], 3);
      chk($sformatf("%s locked[%0d]", tag, i), int'(lk_h[base+i]), (i >= 3) ? 1 : 0);
    end
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    sig_in     = 1'b0;
    en         = 1'b0;
    exp_period = 8'd5;
    repeat (3) @(negedge clk);
    #1;
    chk("reset period", int'(period), 0);
    chk("reset high_time", int'(high_time), 0);
    chk("reset meas_valid", int'(meas_valid), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(negedge clk);

    // divide-by-5 style input, lock after 4 matches
    lock_seq("s1");

    // period 7 breaks lock, 5 re-locks, 6 stays inside TOL=1
    base = vcnt;
    pulses(2, 4, 3);
    chk("s2 last5 period", per_h[base], 5);
    chk("s2 last5 locked", int'(lk_h[base]), 1);
    chk("s2 p7 period", per_h[base+1], 7);
    chk("s2 p7 high", hi_h[base+1], 4);
    chk("s2 p7 locked", int'(lk_h[base+1]), 0);
    pulses(5, 3, 2);
    chk("s2 relock count", vcnt - base, 7);
    chk("s2 relock 3rd", int'(lk_h[base+5]), 0);
    chk("s2 relock 4th", int'(lk_h[base+6]), 1);
    pulses(1, 3, 3);
    pulses(1, 3, 2);
    chk("s2 p6 period", per_h[base+8], 6);
    chk("s2 p6 in tol locked", int'(lk_h[base+8]), 1);

    // hold low: timeout fires 255 cycles after the last edge
    base = vcnt;
    repeat (245) @(negedge clk);
    #1;
    chk("s3 before timeout", int'(timeout), 0);
    chk("s3 locked before timeout", int'(locked), 1);
    repeat (10) @(negedge clk);
    #1;
    chk("s3 timeout", int'(timeout), 1);
    chk("s3 timeout locked", int'(locked), 0);
    chk("s3 period held", int'(period), 6);
    chk("s3 no meas on timeout", vcnt - base, 0);
    pulses(1, 3, 2);
    chk("s3 edge clears timeout", int'(timeout), 0);
    chk("s3 first edge arms", vcnt - base, 0);
    pulses(1, 4, 3);
    chk("s3 second edge meas", vcnt - base, 1);
    chk("s3 second edge period", per_h[base], 5);
    chk("s3 second edge high", hi_h[base], 3);

    // relock, then drop en mid-period
    base = vcnt;
    pulses(5, 3, 2);
    chk("s4 p7 period", per_h[base], 7);
    chk("s4 pre locked 3rd", int'(lk_h[base+3]), 0);
    chk("s4 pre locked 4th", int'(lk_h[base+4]), 1);
    en = 1'b0;
    @(negedge clk);
    #1;
    chk("s4 idle locked", int'(locked), 0);
    chk("s4 idle meas_valid", int'(meas_valid), 0);
    chk("s4 idle period held", int'(period), 5);
    base = vcnt;
    pulses(2, 3, 2);
    chk("s4 disabled no meas", vcnt - base, 0);
    en = 1'b1;
    pulses(1, 3, 2);
    chk("s4 reenable arms only", vcnt - base, 0);
    pulses(1, 3, 2);
    chk("s4 reenable meas", vcnt - base, 1);
    chk("s4 reenable period", per_h[base], 5);
    chk("s4 reenable locked", int'(lk_h[base]), 0);

    // lock, then async reset mid-period
    base = vcnt;
    pulses(4, 3, 2);
    chk("s5 locked before reset", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5 async period", int'(period), 0);
    chk("s5 async high_time", int'(high_time), 0);
    chk("s5 async locked", int'(locked), 0);
    chk("s5 async timeout", int'(timeout), 0);
    chk("s5 async meas_valid", int'(meas_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    lock_seq("s5");

    // exp_period 0 never matches
    exp_period = 8'd0;
    base = vcnt;
    pulses(5, 3, 2);
    chk("s6 meas count", vcnt - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s6 period[%0d]", i), per_h[base+i], 5);
      chk($sformatf("s6 locked[%0d]", i), int'(lk_h[base+i]), 0);
    end

    chk("meas_valid never back-to-back", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures the period and high time of an asynchronous, slow clock-like signal (e.g. an odd/even divider output) in units of `clk` cycles, and reports lock against an expected period. It is the receive/check end for the clock-divider family. The block sits on the reference clock domain and feeds divider self-test logic and status registers.

## Interface
- `CNT_W`, 16: width of the period and high-time counters.
- `SYNC_STAGES`, 2: flip-flop stages in the `sig_in` synchronizer; minimum 2.
- `LOCK_CNT`, 4: number of consecutive in-tolerance periods required to assert `locked`; minimum 1.
- `TOL`, 0: allowed absolute difference between `period` and `exp_period`.

- `clk`  in  1  measurement clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `en`  in  1  measurement enable; level-sensitive.
- `exp_period`  in  CNT_W  expected period in `clk` cycles; 0 means never match.
- `period`  out  CNT_W  last measured period (rising edge to rising edge).
- `high_time`  out  CNT_W  number of `clk` cycles the synchronized signal was high in that period.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  period within tolerance for `LOCK_CNT` consecutive measurements.
- `timeout`  out  1  sticky: no rising edge within 2^CNT_W−1 cycles; cleared by the next rising edge or by `en`=0.

## Operation
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0. The synchronizer, `s_prev`, the counters and `match_cnt` all reset to 0. State resets to IDLE.
- Synchronizer output `s`; `s_prev` is `s` delayed one cycle. The edge signal is `rise = s & ~s_prev`. Falling edges are not used.
- FSM:
  - IDLE: entered when `en`=0. Counters hold at 0, `locked`=0, `timeout`=0, `match_cnt`=0. `period` and `high_time` hold their last values. Moves to ARM when `en`=1.
  - ARM: waits for the first `rise`. On `rise`: `per_cnt`←1, `hi_cnt`←1, no `meas_valid`, move to MEASURE. The timeout counter runs in this state.
  - MEASURE: each cycle without `rise`: `per_cnt`←sat(`per_cnt`+1) and `hi_cnt`←`hi_cnt`+`s`. On `rise`:
    - `period`←`per_cnt` and `high_time`←`hi_cnt`, with `meas_valid`=1 the next cycle.
    - Then `per_cnt`←1 and `hi_cnt`←1.
- Timeout: when `per_cnt` reaches 2^CNT_W−1 (ARM or MEASURE) without `rise`:
  - `timeout`←1, `locked`←0, `match_cnt`←0.
  - Move to ARM. `period` and `high_time` are unchanged and `meas_valid` is not asserted.
- Lock, evaluated on each measurement:
  - Match if `exp_period`≠0 and |`per_cnt`−`exp_period`|≤`TOL`. Use unsigned arithmetic with a CNT_W+1-bit difference.
  - On a match, `match_cnt` increments, saturating at `LOCK_CNT`. On a mismatch, `match_cnt`←0.
  - `locked` = (`match_cnt`==`LOCK_CNT`), registered and updated in the same cycle as `meas_valid`.
- `en` falling in any state → IDLE on the next cycle. A measurement in flight is discarded.
- `rst_n` asserted mid-period → all state returns to reset values immediately. After release, the first `rise` only arms the block.
- `exp_period` may change at any time. It is sampled only at `rise`.

## Timing
- Latency from a `sig_in` rising edge (meeting setup at posedge k) to `s` high is SYNC_STAGES cycles. `meas_valid` then pulses SYNC_STAGES+1 cycles after posedge k.
- The first `meas_valid` after enable occurs at the second rising edge. `locked` asserts at the `LOCK_CNT`-th consecutive matching measurement.
- Minimum measurable period is 2 `clk` cycles. Pulses shorter than one `clk` cycle may be missed, and that is accepted behaviour.
- `meas_valid` is never high on two consecutive cycles.

## Structure
- Package `clk_meter_pkg` holds:
  - The FSM state enum: IDLE, ARM, MEASURE.
  - The function `in_tol(period, exp, tol)`.
- Sub-module `sync_bit` is a parameterised SYNC_STAGES-deep synchronizer with async active-low reset to 0. The remaining logic stays in `clk_ratio_meter`.

## Test plan
- Periodic `sig_in` with period 5 and high time 3 (as from a divide-by-5 clock), `exp_period`=5, `TOL`=0:
  - Every `meas_valid` shows `period`=5, `high_time`=3.
  - `locked` rises with the 4th valid measurement.
  - The first edge produces no `meas_valid`.
- Once locked, switch to period 7 with `TOL`=1:
  - The next `meas_valid` shows `period`=7 and `locked`=0.
  - Switching back to period 5 re-locks after 4 measurements.
- With `CNT_W`=8, hold `sig_in` low after lock:
  - `timeout`=1 and `locked`=0 at 255 cycles.
  - The next two rising edges clear `timeout`, and the second edge gives a valid `period`.
- Drop `en` in mid-period:
  - The next cycle is IDLE with `locked`=0 and no `meas_valid`; `period` holds.
  - Re-enable: the first edge only arms.
- Pulse `rst_n` low mid-period while locked: all outputs go to 0 asynchronously, and the re-lock sequence is identical to the first scenario.
- Set `exp_period`=0 with period-5 input: `meas_valid` pulses normally and `locked` stays 0.
